pls_seq: RTL and testbench

Segment sequencer directly upstream of the step pulse generator. It accepts motion segments (step count, period, direction, pause flag) over a valid/ready interface into a 2-entry queue. It drives the generator's start_clk/stop_clk/T/dir_req/pause_req, counting consumed periods via the generator's `loaded` strobe. It also maintains the signed axis position.

---
 rtl/pls_seq_pkg.sv | 17 +
 rtl/seg_q2.sv | 80 ++++++++
 rtl/pls_seq.sv | 131 +++++++++++++
 tb/tb_pls_seq.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pls_seq_pkg.sv
// Shared types for the segment sequencer feeding the step pulse generator.
package pls_seq_pkg;

    localparam int unsigned SEQ_STEPS_W = 32;
    localparam int unsigned SEQ_T_W     = 32;
    localparam int unsigned SEQ_POS_W   = 32;

    typedef struct packed {
        logic [SEQ_STEPS_W-1:0] steps;
        logic [SEQ_T_W-1:0]     t;
        logic                   dir;
        logic                   pause;
    } seg_t;

    typedef enum logic [1:0] {StIdle, StRun, StStopping} state_t;

endpackage

// File: rtl/seg_q2.sv
// Two-entry segment queue: head (cur) counts down its steps, tail (nxt) promotes when head drains.
import pls_seq_pkg::*;

module seg_q2 (
    input  logic                   clk,
    input  logic                   aclr,
    input  logic                   flush,
    input  logic                   push,
    input  seg_t                   push_seg,
    input  logic                   dec,
    output logic [SEQ_T_W-1:0]     head_t,
    output logic                   head_dir,
    output logic                   head_pause,
    output logic                   head_valid,
    output logic                   full,
    output logic                   pop,
    output logic                   drained
);

    seg_t cur_q, nxt_q;
    logic cur_valid_q, nxt_valid_q;
    logic step, take;

    assign step    = dec && cur_valid_q && !flush && (cur_q.steps != '0);
    assign pop     = step && (cur_q.steps == SEQ_STEPS_W'(1));
    // Zero-step commands are accepted upstream but never stored.
    assign take    = push && !flush && (push_seg.steps != '0);
    assign drained = pop && !nxt_valid_q && !take;

    assign head_valid = cur_valid_q;
    assign full       = nxt_valid_q;

    always_comb begin
        head_t     = '0;
        head_dir   = 1'b0;
        head_pause = 1'b0;
        if (cur_valid_q) begin
            head_t     = cur_q.t;
            head_dir   = cur_q.dir;
            head_pause = cur_q.pause;
        end
    end

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            cur_q       <= '0;
            nxt_q       <= '0;
            cur_valid_q <= 1'b0;
            nxt_valid_q <= 1'b0;
        end else if (flush) begin
            cur_q       <= '0;
            nxt_q       <= '0;
            cur_valid_q <= 1'b0;
            nxt_valid_q <= 1'b0;
        end else if (pop) begin
            if (nxt_valid_q) begin
                cur_q       <= nxt_q;
                nxt_valid_q <= 1'b0;
            end else if (take) begin
                cur_q <= push_seg;
            end else begin
                cur_valid_q <= 1'b0;
            end
        end else begin
            if (step) begin
                cur_q.steps <= cur_q.steps - SEQ_STEPS_W'(1);
            end
            if (take) begin
                if (!cur_valid_q) begin
                    cur_q       <= push_seg;
                    cur_valid_q <= 1'b1;
                end else begin
                    nxt_q       <= push_seg;
                    nxt_valid_q <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/pls_seq.sv
// Segment sequencer: queues motion segments, drives generator start/stop and tracks axis position.
import pls_seq_pkg::*;

module pls_seq #(
    parameter int unsigned STEPS_W = SEQ_STEPS_W,
    parameter int unsigned T_W     = SEQ_T_W,
    parameter int unsigned POS_W   = SEQ_POS_W
) (
    input  logic               clk,
    input  logic               aclr,
    input  logic               abort,
    input  logic               hold,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [STEPS_W-1:0] cmd_steps,
    input  logic [T_W-1:0]     cmd_T,
    input  logic               cmd_dir,
    input  logic               cmd_pause,
    input  logic               start_rdy,
    input  logic               run,
    input  logic               loaded,
    output logic               start_clk,
    output logic               stop_clk,
    output logic [T_W-1:0]     T,
    output logic               dir_req,
    output logic               pause_req,
    output logic               busy,
    output logic               seg_done,
    output logic               underrun,
    input  logic               pos_set,
    input  logic [POS_W-1:0]   pos_val,
    output logic [POS_W-1:0]   pos
);

    state_t           state_q;
    logic             stop_q, seg_done_q, underrun_q;
    logic [POS_W-1:0] pos_q;
    seg_t             cmd_seg;
    logic             head_valid, full, pop, drained, start_ok;

    always_comb begin
        cmd_seg       = '0;
        cmd_seg.steps = cmd_steps;
        cmd_seg.t     = cmd_T;
        cmd_seg.dir   = cmd_dir;
        cmd_seg.pause = cmd_pause;
    end

    assign cmd_ready = !full;

    seg_q2 u_q (
        .clk        (clk),
        .aclr       (aclr),
        .flush      (abort),
        .push       (cmd_valid && cmd_ready),
        .push_seg   (cmd_seg),
        .dec        (loaded),
        .head_t     (T),
        .head_dir   (dir_req),
        .head_pause (pause_req),
        .head_valid (head_valid),
        .full       (full),
        .pop        (pop),
        .drained    (drained)
    );

    // Restart is allowed from STOPPING as well, inside the generator's stop window.
    assign start_ok  = !abort && head_valid && start_rdy && !hold &&
                       (state_q == StIdle || state_q == StStopping);
    assign start_clk = start_ok;

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            state_q    <= StIdle;
            stop_q     <= 1'b0;
            underrun_q <= 1'b0;
            seg_done_q <= 1'b0;
        end else begin
            stop_q     <= 1'b0;
            underrun_q <= 1'b0;
            seg_done_q <= pop;
            if (abort) begin
                state_q <= StIdle;
            end else begin
                unique case (state_q)
                    StIdle, StStopping: begin
                        if (start_ok) begin
                            // A one-period segment can drain on the start cycle itself.
                            if (drained) begin
                                state_q    <= StStopping;
                                stop_q     <= 1'b1;
                                underrun_q <= 1'b1;
                            end else begin
                                state_q <= StRun;
                            end
                        end else if (state_q == StStopping && !head_valid && !full && !run) begin
                            state_q <= StIdle;
                        end
                    end
                    StRun: begin
                        if (drained) begin
                            state_q    <= StStopping;
                            stop_q     <= 1'b1;
                            underrun_q <= 1'b1;
                        end else if (!run) begin
                            state_q <= StIdle;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            pos_q <= '0;
        end else if (pos_set) begin
            pos_q <= pos_val;
        end else if (loaded && head_valid && !pause_req && !abort) begin
            pos_q <= dir_req ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
        end
    end

    assign stop_clk = stop_q;
    assign seg_done = seg_done_q;
    assign underrun = underrun_q;
    assign pos      = pos_q;
    assign busy     = head_valid || full || (state_q != StIdle);

endmodule

// File: tb/tb_pls_seq.sv
// Directed bench for pls_seq; the generator is driven by hand, cycle by cycle.
module tb_pls_seq;

    logic        clk = 1'b0;
    logic        aclr, abort, hold;
    logic        cmd_valid, cmd_ready;
    logic [31:0] cmd_steps, cmd_T;
    logic        cmd_dir, cmd_pause;
    logic        start_rdy, run, loaded;
    logic        start_clk, stop_clk;
    logic [31:0] T;
    logic        dir_req, pause_req, busy, seg_done, underrun;
    logic        pos_set;
    logic [31:0] pos_val, pos;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pls_seq dut (
        .clk       (clk),
        .aclr      (aclr),
        .abort     (abort),
        .hold      (hold),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_steps (cmd_steps),
        .cmd_T     (cmd_T),
        .cmd_dir   (cmd_dir),
        .cmd_pause (cmd_pause),
        .start_rdy (start_rdy),
        .run       (run),
        .loaded    (loaded),
        .start_clk (start_clk),
        .stop_clk  (stop_clk),
        .T         (T),
        .dir_req   (dir_req),
        .pause_req (pause_req),
        .busy      (busy),
        .seg_done  (seg_done),
        .underrun  (underrun),
        .pos_set   (pos_set),
        .pos_val   (pos_val),
        .pos       (pos)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] s, input logic [31:0] t, input logic d, input logic p);
        cmd_valid = 1'b1;
        cmd_steps = s;
        cmd_T     = t;
        cmd_dir   = d;
        cmd_pause = p;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic load();
        loaded = 1'b1;
        tick();
        loaded = 1'b0;
    endtask

    task automatic start_load();
        start_rdy = 1'b1;
        loaded    = 1'b1;
        #1;
        chk("start_clk_on_start", {63'd0, start_clk}, 64'd1);
        tick();
        start_rdy = 1'b0;
        loaded    = 1'b0;
        run       = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        aclr = 1'b1; abort = 1'b0; hold = 1'b0;
        cmd_valid = 1'b0; cmd_steps = '0; cmd_T = '0; cmd_dir = 1'b0; cmd_pause = 1'b0;
        start_rdy = 1'b0; run = 1'b0; loaded = 1'b0; pos_set = 1'b0; pos_val = '0;
        tick();
        tick();
        aclr = 1'b0;
        tick();
        chk("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_pos", {32'd0, pos}, 64'd0);
        chk("rst_T", {32'd0, T}, 64'd0);
        chk("rst_dir_pause", {62'd0, dir_req, pause_req}, 64'd0);
        chk("rst_pulses", {61'd0, stop_clk, seg_done, underrun}, 64'd0);
        chk("rst_start_clk", {63'd0, start_clk}, 64'd0);

        // 1: single segment {3, 10, +}
        send(32'd3, 32'd10, 1'b1, 1'b0);
        chk("t1_T", {32'd0, T}, 64'd10);
        chk("t1_busy", {63'd0, busy}, 64'd1);
        start_load();
        chk("t1_pos1", {32'd0, pos}, 64'd1);
        chk("t1_no_start_in_run", {63'd0, start_clk}, 64'd0);
        repeat (9) tick();
        load();
        chk("t1_pos2", {32'd0, pos}, 64'd2);
        chk("t1_no_stop_mid", {63'd0, stop_clk}, 64'd0);
        repeat (9) tick();
        load();
        chk("t1_pos3", {32'd0, pos}, 64'd3);
        chk("t1_stop_done_under", {61'd0, stop_clk, seg_done, underrun}, 64'd7);
        chk("t1_T_empty", {32'd0, T}, 64'd0);
        tick();
        chk("t1_pulses_one_cycle", {61'd0, stop_clk, seg_done, underrun}, 64'd0);
        chk("t1_busy_stopping", {63'd0, busy}, 64'd1);
        run = 1'b0;
        tick();
        chk("t1_idle", {63'd0, busy}, 64'd0);

        // 2: back-to-back {2, 8, +} then {2, 12, -}
        pos_set = 1'b1; pos_val = 32'd0;
        tick();
        pos_set = 1'b0;
        chk("t2_pos_set0", {32'd0, pos}, 64'd0);
        send(32'd2, 32'd8, 1'b1, 1'b0);
        send(32'd2, 32'd12, 1'b0, 1'b0);
        chk("t2_full", {63'd0, cmd_ready}, 64'd0);
        chk("t2_T8", {32'd0, T}, 64'd8);
        start_load();
        repeat (7) tick();
        chk("t2_T8_held", {32'd0, T}, 64'd8);
        load();
        chk("t2_pos2", {32'd0, pos}, 64'd2);
        chk("t2_T12", {32'd0, T}, 64'd12);
        chk("t2_dir0", {63'd0, dir_req}, 64'd0);
        chk("t2_done_nostop", {62'd0, seg_done, stop_clk}, 64'd2);
        chk("t2_ready", {63'd0, cmd_ready}, 64'd1);
        repeat (11) tick();
        load();
        chk("t2_pos1", {32'd0, pos}, 64'd1);
        chk("t2_no_stop", {62'd0, stop_clk, seg_done}, 64'd0);
        load();
        chk("t2_pos0", {32'd0, pos}, 64'd0);
        chk("t2_end", {61'd0, stop_clk, seg_done, underrun}, 64'd7);
        run = 1'b0;
        tick();
        chk("t2_idle", {63'd0, busy}, 64'd0);

        // 3: dwell between motions
        send(32'd1, 32'd10, 1'b1, 1'b0);
        send(32'd4, 32'd10, 1'b1, 1'b1);
        chk("t3_pause_low_first", {63'd0, pause_req}, 64'd0);
        start_load();
        chk("t3_pos1", {32'd0, pos}, 64'd1);
        chk("t3_done_pause", {62'd0, seg_done, pause_req}, 64'd3);
        send(32'd1, 32'd10, 1'b0, 1'b0);
        load(); load(); load();
        chk("t3_dwell_pos", {32'd0, pos}, 64'd1);
        chk("t3_dwell_pause", {63'd0, pause_req}, 64'd1);
        load();
        chk("t3_dwell_end_pos", {32'd0, pos}, 64'd1);
        chk("t3_after_dwell", {61'd0, pause_req, dir_req, seg_done}, 64'd1);
        chk("t3_no_stop", {63'd0, stop_clk}, 64'd0);
        load();
        chk("t3_pos0", {32'd0, pos}, 64'd0);
        chk("t3_stop", {63'd0, stop_clk}, 64'd1);
        run = 1'b0;
        tick();

        // 4: queue full, third command waits for promotion, zero-step dropped
        send(32'd1, 32'd5, 1'b1, 1'b0);
        send(32'd2, 32'd6, 1'b1, 1'b0);
        chk("t4_full", {63'd0, cmd_ready}, 64'd0);
        cmd_valid = 1'b1; cmd_steps = 32'd1; cmd_T = 32'd7; cmd_dir = 1'b0; cmd_pause = 1'b0;
        start_rdy = 1'b1; loaded = 1'b1;
        #1;
        chk("t4_start", {63'd0, start_clk}, 64'd1);
        chk("t4_not_ready", {63'd0, cmd_ready}, 64'd0);
        tick();
        start_rdy = 1'b0; loaded = 1'b0; run = 1'b1;
        chk("t4_ready_after_promote", {63'd0, cmd_ready}, 64'd1);
        chk("t4_seg_done", {63'd0, seg_done}, 64'd1);
        chk("t4_T6", {32'd0, T}, 64'd6);
        tick();
        cmd_valid = 1'b0;
        chk("t4_third_accepted", {63'd0, cmd_ready}, 64'd0);
        load();
        load();
        chk("t4_pos3", {32'd0, pos}, 64'd3);
        chk("t4_T7", {32'd0, T}, 64'd7);
        send(32'd0, 32'd99, 1'b1, 1'b0);
        chk("t4_zero_dropped_ready", {63'd0, cmd_ready}, 64'd1);
        chk("t4_zero_dropped_T", {32'd0, T}, 64'd7);
        chk("t4_zero_no_done", {63'd0, seg_done}, 64'd0);
        load();
        chk("t4_pos2", {32'd0, pos}, 64'd2);
        chk("t4_stop", {62'd0, stop_clk, underrun}, 64'd3);
        run = 1'b0;
        tick();
        chk("t4_idle", {63'd0, busy}, 64'd0);

        // 5: abort mid-segment, then pos_set racing loaded
        send(32'd6, 32'd10, 1'b1, 1'b0);
        send(32'd3, 32'd10, 1'b1, 1'b0);
        start_load();
        chk("t5_pos3", {32'd0, pos}, 64'd3);
        abort = 1'b1; run = 1'b0; start_rdy = 1'b1;
        #1;
        chk("t5_abort_no_start", {63'd0, start_clk}, 64'd0);
        tick();
        abort = 1'b0; start_rdy = 1'b0;
        chk("t5_busy", {63'd0, busy}, 64'd0);
        chk("t5_ready", {63'd0, cmd_ready}, 64'd1);
        chk("t5_no_pulses", {62'd0, seg_done, stop_clk}, 64'd0);
        chk("t5_pos_hold", {32'd0, pos}, 64'd3);
        chk("t5_T0", {32'd0, T}, 64'd0);
        send(32'd2, 32'd10, 1'b1, 1'b0);
        pos_set = 1'b1; pos_val = 32'hFFFF_FFF9;
        start_load();
        pos_set = 1'b0;
        chk("t5_pos_set_wins", {32'd0, pos}, 64'hFFFF_FFF9);
        load();
        chk("t5_pos_m6", {32'd0, pos}, 64'hFFFF_FFFA);
        chk("t5_stop", {63'd0, stop_clk}, 64'd1);
        run = 1'b0;
        tick();

        // 6: restart from STOPPING, blocked first by hold
        send(32'd1, 32'd10, 1'b1, 1'b0);
        start_load();
        chk("t6_stop", {62'd0, stop_clk, underrun}, 64'd3);
        chk("t6_pos_m5", {32'd0, pos}, 64'hFFFF_FFFB);
        hold = 1'b1; start_rdy = 1'b1;
        send(32'd2, 32'd10, 1'b1, 1'b0);
        #1;
        chk("t6_hold_blocks", {63'd0, start_clk}, 64'd0);
        tick();
        chk("t6_hold_busy", {63'd0, busy}, 64'd1);
        chk("t6_hold_still_blocks", {63'd0, start_clk}, 64'd0);
        hold = 1'b0; loaded = 1'b1;
        #1;
        chk("t6_restart", {63'd0, start_clk}, 64'd1);
        tick();
        loaded = 1'b0;
        chk("t6_in_run", {63'd0, start_clk}, 64'd0);
        chk("t6_pos_m4", {32'd0, pos}, 64'hFFFF_FFFC);
        chk("t6_no_stop", {63'd0, stop_clk}, 64'd0);
        load();
        chk("t6_pos_m3", {32'd0, pos}, 64'hFFFF_FFFD);
        chk("t6_final_stop", {63'd0, stop_clk}, 64'd1);
        start_rdy = 1'b0; run = 1'b0;
        tick();
        chk("t6_idle", {63'd0, busy}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
